// File: rtl/idma_desc64_submit_buffer.sv
// Per-channel descriptor address FIFOs fed from a register bus,
// with STATUS readback, flush and an optional stall timeout.
module idma_desc64_submit_buffer #(
  parameter int unsigned          NumChannels   = 4,
  parameter int unsigned          FifoDepth     = 4,
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 64,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter int unsigned          ChannelStride = 16,
  parameter int unsigned          StallTimeout  = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [AddrWidth-1:0]                  reg_addr_i,
  input  logic                                  reg_write_i,
  input  logic [DataWidth-1:0]                  reg_wdata_i,
  input  logic [DataWidth/8-1:0]                reg_wstrb_i,
  input  logic                                  reg_valid_i,
  output logic [DataWidth-1:0]                  reg_rdata_o,
  output logic                                  reg_error_o,
  output logic                                  reg_ready_o,
  output logic [NumChannels-1:0][DataWidth-1:0] desc_addr_o,
  output logic [NumChannels-1:0]                desc_valid_o,
  input  logic [NumChannels-1:0]                desc_ready_i
);

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned StallW = $clog2(StallTimeout + 2);
  localparam int unsigned ChW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef logic [PtrW-1:0]      ptr_t;
  typedef logic [CntW-1:0]      cnt_t;
  typedef logic [DataWidth-1:0] data_t;

  data_t mem_q [NumChannels][FifoDepth];
  data_t mem_d [NumChannels][FifoDepth];
  ptr_t  rptr_q [NumChannels];
  ptr_t  rptr_d [NumChannels];
  ptr_t  wptr_q [NumChannels];
  ptr_t  wptr_d [NumChannels];
  cnt_t  cnt_q  [NumChannels];
  cnt_t  cnt_d  [NumChannels];

  logic [NumChannels-1:0] drop_q, drop_d;
  logic [StallW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [AddrWidth-1:0]   stall_addr_q, stall_addr_d;

  logic [NumChannels-1:0] desc_hit, stat_hit;
  logic [NumChannels-1:0] full, empty, pop;
  logic [NumChannels-1:0] push, flush, stat_rd, drop_set;
  logic [ChW-1:0]         sel;
  logic                   stall;
  logic                   timeout_hit;
  data_t                  status;

  function automatic logic [AddrWidth-1:0] win_addr(
    input int unsigned c,
    input int unsigned off
  );
    return BaseAddr + AddrWidth'(c * ChannelStride + off);
  endfunction

  always_comb begin
    desc_hit = '0;
    stat_hit = '0;
    sel      = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (reg_addr_i == win_addr(c, 0)) begin
        desc_hit[c] = 1'b1;
        sel         = ChW'(c);
      end
      if (reg_addr_i == win_addr(c, 8)) begin
        stat_hit[c] = 1'b1;
        sel         = ChW'(c);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      full[c]         = (cnt_q[c] == CntW'(FifoDepth));
      empty[c]        = (cnt_q[c] == '0);
      desc_valid_o[c] = !empty[c];
      desc_addr_o[c]  = mem_q[c][rptr_q[c]];
      pop[c]          = !empty[c] && desc_ready_i[c];
    end
  end

  always_comb begin
    status        = '0;
    status[15:0]  = 16'(cnt_q[sel]);
    status[16]    = full[sel];
    status[17]    = empty[sel];
    status[18]    = drop_q[sel];
  end

  assign timeout_hit = (StallTimeout != 0)
                    && (stall_cnt_q == StallW'(StallTimeout))
                    && (reg_addr_i == stall_addr_q);

  always_comb begin
    reg_ready_o = 1'b0;
    reg_error_o = 1'b0;
    reg_rdata_o = '0;
    push        = '0;
    flush       = '0;
    stat_rd     = '0;
    drop_set    = '0;
    stall       = 1'b0;
    if (reg_valid_i) begin
      if (|desc_hit) begin
        if (!reg_write_i || !(&reg_wstrb_i)) begin
          reg_ready_o = 1'b1;
          reg_error_o = 1'b1;
        end else if (!full[sel]) begin
          reg_ready_o = 1'b1;
          push[sel]   = 1'b1;
        end else if (timeout_hit) begin
          reg_ready_o   = 1'b1;
          reg_error_o   = 1'b1;
          drop_set[sel] = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end else if (|stat_hit) begin
        reg_ready_o = 1'b1;
        if (reg_write_i) begin
          flush[sel] = reg_wdata_i[0];
        end else begin
          reg_rdata_o  = status;
          stat_rd[sel] = 1'b1;
        end
      end else begin
        reg_ready_o = 1'b1;
        reg_error_o = 1'b1;
      end
    end
  end

  // A new stalled address restarts the run at one cycle.
  always_comb begin
    stall_cnt_d  = '0;
    stall_addr_d = stall_addr_q;
    if (stall && (StallTimeout != 0)) begin
      stall_addr_d = reg_addr_i;
      if ((stall_cnt_q != '0) && (reg_addr_i != stall_addr_q)) begin
        stall_cnt_d = StallW'(1);
      end else begin
        stall_cnt_d = stall_cnt_q + StallW'(1);
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      rptr_d[c] = rptr_q[c];
      wptr_d[c] = wptr_q[c];
      cnt_d[c]  = cnt_q[c];
      drop_d[c] = drop_set[c] | (drop_q[c] & ~stat_rd[c]);
      if (flush[c]) begin
        rptr_d[c] = '0;
        wptr_d[c] = '0;
        cnt_d[c]  = '0;
      end else begin
        if (push[c]) begin
          mem_d[c][wptr_q[c]] = reg_wdata_i;
          wptr_d[c]           = wptr_q[c] + ptr_t'(1);
        end
        if (pop[c]) begin
          rptr_d[c] = rptr_q[c] + ptr_t'(1);
        end
        if (push[c] && !pop[c]) begin
          cnt_d[c] = cnt_q[c] + cnt_t'(1);
        end else if (pop[c] && !push[c]) begin
          cnt_d[c] = cnt_q[c] - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        rptr_q[c] <= '0;
        wptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      drop_q       <= '0;
      stall_cnt_q  <= '0;
      stall_addr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        rptr_q[c] <= rptr_d[c];
        wptr_q[c] <= wptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      drop_q       <= drop_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_addr_q <= stall_addr_d;
    end
  end

  // Storage needs no reset: a zero count masks stale entries.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_idma_desc64_submit_buffer.sv
// Bench for idma_desc64_submit_buffer: directed scenarios plus random
// traffic, checked against a queue-based model of the channels.
module tb_idma_desc64_submit_buffer;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [31:0]          reg_addr;
  logic                 reg_write;
  logic [63:0]          reg_wdata;
  logic [7:0]           reg_wstrb;
  logic                 reg_valid;
  logic [63:0]          reg_rdata;
  logic                 reg_error;
  logic                 reg_ready;
  logic [NCH-1:0][63:0] desc_addr;
  logic [NCH-1:0]       desc_valid;
  logic [NCH-1:0]       desc_ready;

  idma_desc64_submit_buffer #(
    .NumChannels  (NCH),
    .FifoDepth    (DEPTH),
    .AddrWidth    (32),
    .DataWidth    (64),
    .BaseAddr     (32'h0),
    .ChannelStride(16),
    .StallTimeout (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_addr_i  (reg_addr),
    .reg_write_i (reg_write),
    .reg_wdata_i (reg_wdata),
    .reg_wstrb_i (reg_wstrb),
    .reg_valid_i (reg_valid),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .reg_ready_o (reg_ready),
    .desc_addr_o (desc_addr),
    .desc_valid_o(desc_valid),
    .desc_ready_i(desc_ready)
  );

  always #5 clk = ~clk;

  logic [63:0] mq [NCH][$];
  bit          mdrop [NCH];
  int          mstall;
  logic [31:0] mstall_addr;
  int          n_checks;
  int          n_fail;

  logic        rr, re;
  logic [63:0] rd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mdrop[c] = 1'b0;
    end
    mstall      = 0;
    mstall_addr = '0;
  endtask

  // One bus cycle: drive at posedge+1, check at posedge+4, advance model.
  task automatic step(input bit v, input bit w, input logic [31:0] a,
                      input logic [63:0] d, input logic [7:0] s,
                      input logic [3:0] dr, output logic o_rdy,
                      output logic o_err, output logic [63:0] o_rd);
    logic        er, ee;
    logic [63:0] erd;
    int          ch, off, push_ch, flush_ch, rd_ch, set_ch;
    bit          stalled;
    reg_valid  = v;
    reg_write  = w;
    reg_addr   = a;
    reg_wdata  = d;
    reg_wstrb  = s;
    desc_ready = dr;
    #3;
    er = 0; ee = 0; erd = '0; stalled = 0;
    ch = -1; off = -1;
    push_ch = -1; flush_ch = -1; rd_ch = -1; set_ch = -1;
    if (v) begin
      if (a < 32'(NCH * 16)) begin
        ch  = int'(a) / 16;
        off = int'(a) % 16;
      end
      if (off == 0) begin
        if (!w || s != 8'hFF) begin
          er = 1; ee = 1;
        end else if (mq[ch].size() < DEPTH) begin
          er = 1; push_ch = ch;
        end else if (mstall == TO && a == mstall_addr) begin
          er = 1; ee = 1; set_ch = ch;
        end else begin
          stalled = 1;
        end
      end else if (off == 8) begin
        er = 1;
        if (w) begin
          if (d[0]) flush_ch = ch;
        end else begin
          erd = {45'd0, mdrop[ch], mq[ch].size() == 0,
                 mq[ch].size() == DEPTH, 16'(mq[ch].size())};
          rd_ch = ch;
        end
      end else begin
        er = 1; ee = 1;
      end
    end
    o_rdy = reg_ready;
    o_err = reg_error;
    o_rd  = reg_rdata;
    chk("ready", reg_ready, er);
    chk("error", reg_error, ee);
    chk("rdata", reg_rdata, erd);
    for (int c = 0; c < NCH; c++) begin
      chk("valid", desc_valid[c], mq[c].size() != 0);
      if (mq[c].size() != 0) chk("head", desc_addr[c], mq[c][0]);
    end
    if (stalled) begin
      mstall      = (mstall != 0 && a != mstall_addr) ? 1 : mstall + 1;
      mstall_addr = a;
    end else begin
      mstall = 0;
    end
    for (int c = 0; c < NCH; c++)
      if (mq[c].size() != 0 && dr[c]) void'(mq[c].pop_front());
    if (push_ch >= 0) mq[push_ch].push_back(d);
    if (flush_ch >= 0) mq[flush_ch].delete();
    if (rd_ch >= 0) mdrop[rd_ch] = 1'b0;
    if (set_ch >= 0) mdrop[set_ch] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d,
                    input logic [3:0] dr);
    step(1, 1, a, d, 8'hFF, dr, rr, re, rd);
  endtask

  task automatic rd_stat(input int ch, input logic [3:0] dr);
    step(1, 0, 32'(ch * 16 + 8), '0, 8'hFF, dr, rr, re, rd);
  endtask

  task automatic idle(input logic [3:0] dr);
    step(0, 0, '0, '0, '0, dr, rr, re, rd);
  endtask

  bit          pv, pw;
  logic [31:0] pa;
  logic [63:0] pd;
  logic [7:0]  ps;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni = 1'b0;
    reg_valid = 0; reg_write = 0; reg_addr = '0;
    reg_wdata = '0; reg_wstrb = '0; desc_ready = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", desc_valid, '0);
    rst_ni = 1'b1;

    rd_stat(0, 4'b0);
    chk("rst_status", rd, 64'h2_0000);

    wr(32'h0, 64'h1000, 4'b0);
    chk("s34_rdy", rr, 1'b1);
    chk("s34_err", re, 1'b0);
    chk("s34_valid", desc_valid[0], 1'b1);
    chk("s34_addr", desc_addr[0], 64'h1000);
    idle(4'b0001);

    for (int i = 0; i < 4; i++) wr(32'd16, 64'h2000 + 64'(i), 4'b0);
    wr(32'd16, 64'h2004, 4'b0);
    chk("s35_stall", rr, 1'b0);
    wr(32'd16, 64'h2004, 4'b0010);
    chk("s35_stall_pop", rr, 1'b0);
    wr(32'd16, 64'h2004, 4'b0);
    chk("s35_accept", rr, 1'b1);
    chk("s35_head", desc_addr[1], 64'h2001);
    repeat (5) idle(4'b0010);

    for (int i = 0; i < 4; i++) wr(32'd32, 64'h3000 + 64'(i), 4'b0);
    for (int i = 0; i < TO; i++) begin
      wr(32'd32, 64'h3004, 4'b0);
      chk("s36_hold", rr, 1'b0);
    end
    wr(32'd32, 64'h3004, 4'b0);
    chk("s36_rdy", rr, 1'b1);
    chk("s36_err", re, 1'b1);
    rd_stat(2, 4'b0);
    chk("s36_drop", rd[18], 1'b1);
    chk("s36_cnt", rd[15:0], 64'd4);
    rd_stat(2, 4'b0);
    chk("s36_drop_clr", rd[18], 1'b0);
    repeat (4) idle(4'b0100);

    for (int i = 0; i < 3; i++) wr(32'd48, 64'h4000 + 64'(i), 4'b0);
    step(1, 1, 32'd56, 64'h1, 8'hFF, 4'b1000, rr, re, rd);
    chk("s37_rdy", rr, 1'b1);
    chk("s37_valid", desc_valid[3], 1'b0);
    rd_stat(3, 4'b0);
    chk("s37_cnt", rd[15:0], 64'd0);

    step(1, 0, 32'd4, '0, 8'hFF, 4'b0, rr, re, rd);
    chk("s38_bad_rdy", rr, 1'b1);
    chk("s38_bad_err", re, 1'b1);
    step(1, 1, 32'd0, 64'h5555, 8'h0F, 4'b0, rr, re, rd);
    chk("s38_strb_err", re, 1'b1);
    idle(4'b0);
    chk("s38_nopush", desc_valid[0], 1'b0);

    wr(32'd0, 64'h6000, 4'b0);
    wr(32'd0, 64'h6001, 4'b0);
    wr(32'd0, 64'h6002, 4'b0001);
    rd_stat(0, 4'b0);
    chk("s39_cnt", rd[15:0], 64'd2);
    chk("s39_head", desc_addr[0], 64'h6001);

    wr(32'd16, 64'h7000, 4'b0);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_valid", desc_valid, '0);
    model_clear();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    rd_stat(0, 4'b0);
    chk("rst_mid_status", rd, 64'h2_0000);

    pv = 0; pw = 0; pa = '0; pd = '0; ps = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) >= 3 || i == 0) begin
        int ch, k;
        ch = $urandom_range(0, NCH - 1);
        k  = $urandom_range(0, 9);
        pv = ($urandom_range(0, 9) != 0);
        pd = {$urandom, $urandom};
        ps = 8'hFF;
        pw = 1;
        pa = 32'(ch * 16);
        if (k == 5) ps = 8'($urandom);
        else if (k == 6) begin pw = 0; pa = 32'(ch * 16 + 8); end
        else if (k == 7) begin
          pa = 32'(ch * 16 + 8);
          pd = ($urandom_range(0, 3) == 0) ? 64'h1 : 64'h2;
        end
        else if (k == 8) pw = 0;
        else if (k == 9) begin
          pa = 32'($urandom_range(0, 255));
          pw = 1'($urandom);
        end
      end
      step(pv, pw, pa, pd, ps, 4'($urandom) & 4'($urandom), rr, re, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
